medevac_env_ctrl: RTL and testbench

Parametrised environment controller for the drone MedEvac pod. It replaces the fixed 6-sensor controller with N_WARN warning-class and N_CRIT critical-class sensor channels. Each channel has a persistence (debounce) filter. The 4-state severity FSM includes an ACK re-arm timeout. The block sits between the sensor flag synchroniser and the actuator drivers and operator alarm panel.

---
 rtl/medevac_pkg.sv | 12 +
 rtl/medevac_debounce.sv | 38 +++
 rtl/medevac_env_ctrl.sv | 117 +++++++++++
 tb/tb_medevac_env_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/medevac_pkg.sv
// Shared constants for the MedEvac pod environment controller:
// severity-state encoding and re-arm timer width.
package medevac_pkg;

   localparam logic [1:0] ST_NORMAL   = 2'b00;
   localparam logic [1:0] ST_WARNING  = 2'b01;
   localparam logic [1:0] ST_CRITICAL = 2'b10;
   localparam logic [1:0] ST_ACKED    = 2'b11;

   localparam int TMR_W = 16;

endpackage

// File: rtl/medevac_debounce.sv
// Persistence filter for one sensor flag: the filtered level follows raw only
// after raw has differed from it for DEB_CNT consecutive rising edges.
module medevac_debounce
   import medevac_pkg::*;
#(
   parameter int DEB_CNT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt
);

   localparam logic [7:0] CNT_LAST = 8'(DEB_CNT - 1);

   logic [7:0] r_cnt;
   logic       r_filt;

   // Count consecutive disagreeing cycles; toggle and restart on the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= 8'd0;
         r_filt <= 1'b0;
      end else if (raw == r_filt) begin
         r_cnt  <= 8'd0;
         r_filt <= r_filt;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt  <= 8'd0;
         r_filt <= ~r_filt;
      end else begin
         r_cnt  <= r_cnt + 8'd1;
         r_filt <= r_filt;
      end
   end

   assign filt = r_filt;

endmodule

// File: rtl/medevac_env_ctrl.sv
// MedEvac pod environment controller: debounced warning/critical channels feed
// a 4-state severity FSM with ACK re-arm. Optional cause log: MEDEVAC_CAUSE_LOG_EN.
module medevac_env_ctrl
   import medevac_pkg::*;
#(
   parameter int N_WARN      = 2,
   parameter int N_CRIT      = 4,
   parameter int DEB_CNT     = 3,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_WARN-1:0] warn_raw,
   input  logic [N_CRIT-1:0] crit_raw,
   input  logic              ack,
   input  logic              clr_cause,
   output logic [N_WARN-1:0] warn_act,
   output logic              crit_act,
   output logic              alarm,
   output logic [1:0]        state,
   output logic [N_CRIT-1:0] crit_cause
);

   localparam logic             TO_EN    = (ACK_TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   logic [N_WARN-1:0] w_warn_filt;
   logic [N_CRIT-1:0] w_crit_filt;
   logic              w_w;
   logic              w_c;
   logic              w_timeout;
   logic [1:0]        w_state_nxt;
   logic [1:0]        r_state;
   logic [TMR_W-1:0]  r_timer;

   for (genvar g = 0; g < N_WARN; g++) begin : g_warn
      medevac_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (warn_raw[g]),
         .filt (w_warn_filt[g])
      );
   end

   for (genvar g = 0; g < N_CRIT; g++) begin : g_crit
      medevac_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
         .clk  (clk),
         .rst  (rst),
         .raw  (crit_raw[g]),
         .filt (w_crit_filt[g])
      );
   end

   assign w_w       = |w_warn_filt;
   assign w_c       = |w_crit_filt;
   assign w_timeout = TO_EN && (r_timer == TMR_LAST);

   // Severity next-state; a cleared critical condition always beats ack.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_NORMAL, ST_WARNING: begin
            if (w_c)      w_state_nxt = ST_CRITICAL;
            else if (w_w) w_state_nxt = ST_WARNING;
            else          w_state_nxt = ST_NORMAL;
         end
         ST_CRITICAL: begin
            if (!w_c)     w_state_nxt = w_w ? ST_WARNING : ST_NORMAL;
            else if (ack) w_state_nxt = ST_ACKED;
            else          w_state_nxt = ST_CRITICAL;
         end
         ST_ACKED: begin
            if (!w_c)           w_state_nxt = w_w ? ST_WARNING : ST_NORMAL;
            else if (w_timeout) w_state_nxt = ST_CRITICAL;
            else                w_state_nxt = ST_ACKED;
         end
         default: w_state_nxt = ST_NORMAL;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_NORMAL;
      else     r_state <= w_state_nxt;
   end

   // Re-arm timer: counts edges spent in ACKED, held at zero otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 r_timer <= {TMR_W{1'b0}};
      else if (w_state_nxt != ST_ACKED)        r_timer <= {TMR_W{1'b0}};
      else if (r_state == ST_ACKED && TO_EN)   r_timer <= r_timer + TMR_W'(1);
      else                                     r_timer <= r_timer;
   end

   assign warn_act = w_c ? {N_WARN{1'b0}} : w_warn_filt;
   assign crit_act = w_c;
   assign alarm    = (r_state == ST_CRITICAL);
   assign state    = r_state;

`ifdef MEDEVAC_CAUSE_LOG_EN
   logic [N_CRIT-1:0] r_cause;

   // Sticky cause log; a coincident set survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_cause <= {N_CRIT{1'b0}};
      else if (clr_cause) r_cause <= w_crit_filt;
      else                r_cause <= r_cause | w_crit_filt;
   end

   assign crit_cause = r_cause;
`else
   logic w_unused_clr;
   assign w_unused_clr = clr_cause;
   assign crit_cause   = {N_CRIT{1'b0}};
`endif

endmodule

// File: tb/tb_medevac_env_ctrl.sv
// Self-checking bench for medevac_env_ctrl: two instances (ACK_TIMEOUT 16 and 0)
// share stimulus and are checked against a history-based behavioural model.
module tb_medevac_env_ctrl;

   localparam int NW  = 2;
   localparam int NC  = 4;
   localparam int DEB = 3;
   localparam int NCH = NW + NC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NW-1:0] warn_raw = '0;
   logic [NC-1:0] crit_raw = '0;
   logic          ack = 1'b0;
   logic          clr_cause = 1'b0;

   logic [NW-1:0] warn_act_a, warn_act_b;
   logic          crit_act_a, crit_act_b, alarm_a, alarm_b;
   logic [1:0]    state_a, state_b;
   logic [NC-1:0] cause_a, cause_b;
   logic [9:0]    act_a, act_b;

   int n_cmp = 0;
   int n_err = 0;

   medevac_env_ctrl #(.N_WARN(NW), .N_CRIT(NC), .DEB_CNT(DEB), .ACK_TIMEOUT(16)) u_dut_a (
      .clk(clk), .rst(rst), .warn_raw(warn_raw), .crit_raw(crit_raw), .ack(ack),
      .clr_cause(clr_cause), .warn_act(warn_act_a), .crit_act(crit_act_a),
      .alarm(alarm_a), .state(state_a), .crit_cause(cause_a));

   medevac_env_ctrl #(.N_WARN(NW), .N_CRIT(NC), .DEB_CNT(DEB), .ACK_TIMEOUT(0)) u_dut_b (
      .clk(clk), .rst(rst), .warn_raw(warn_raw), .crit_raw(crit_raw), .ack(ack),
      .clr_cause(clr_cause), .warn_act(warn_act_b), .crit_act(crit_act_b),
      .alarm(alarm_b), .state(state_b), .crit_cause(cause_b));

   assign act_a = {state_a, alarm_a, crit_act_a, warn_act_a, cause_a};
   assign act_b = {state_b, alarm_b, crit_act_b, warn_act_b, cause_b};

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- behavioural reference model ----------------
   // States as integers 0..3 (NORMAL, WARNING, CRITICAL, ACKED).
   int            to_cfg [2] = '{16, 0};
   int            m_st   [2];
   int            m_acked[2];   // edges already completed while in ACKED
   logic [NCH-1:0] m_filt;
   logic [NCH-1:0] m_hist [DEB]; // raw samples, index 0 newest
   logic [NC-1:0]  m_cause;
   int  mnxt;
   bit  mw, mc, all_diff;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_filt  = '0;
         m_cause = '0;
         for (int j = 0; j < DEB; j++) m_hist[j] = '0;
         for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_acked[k] = 0; end
      end else begin
         mw = |m_filt[NW-1:0];
         mc = |m_filt[NCH-1:NW];
         for (int k = 0; k < 2; k++) begin
            if (!mc)                 mnxt = mw ? 1 : 0;
            else if (m_st[k] < 2)    mnxt = 2;
            else if (m_st[k] == 2)   mnxt = ack ? 3 : 2;
            else if (to_cfg[k] != 0 && m_acked[k] + 1 == to_cfg[k]) mnxt = 2;
            else                     mnxt = 3;
            m_acked[k] = (m_st[k] == 3 && mnxt == 3) ? m_acked[k] + 1 : 0;
            m_st[k]    = mnxt;
         end
`ifdef MEDEVAC_CAUSE_LOG_EN
         m_cause = (clr_cause ? '0 : m_cause) | m_filt[NCH-1:NW];
`endif
         for (int j = DEB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = {crit_raw, warn_raw};
         // A level change is accepted once the last DEB samples all disagree.
         for (int ch = 0; ch < NCH; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
               if (m_hist[j][ch] == m_filt[ch]) all_diff = 1'b0;
            if (all_diff) m_filt[ch] = ~m_filt[ch];
         end
      end
   end

   function automatic logic [9:0] exp_vec(int k);
      logic c;
      c = |m_filt[NCH-1:NW];
      return {2'(m_st[k]), (m_st[k] == 2), c, (c ? {NW{1'b0}} : m_filt[NW-1:0]), m_cause};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_cmp++;
      if ({act_a, act_b} !== 20'd0) begin
         n_err++; $display("FAIL reset_initial act=%h exp=%h", {act_a, act_b}, 20'd0);
      end
      crit_raw = 4'b1111;
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)} || state_a !== 2'b10) begin
         n_err++; $display("FAIL reset_precrit act=%h exp=%h", {act_a, act_b}, {exp_vec(0), exp_vec(1)});
      end
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({act_a, act_b} !== 20'd0) begin
         n_err++; $display("FAIL reset_async act=%h exp=%h", {act_a, act_b}, 20'd0);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) step();
      #3 rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
      step(); step();
      n_cmp++;
      if ({crit_act_a, state_a} !== 3'b000 || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
         n_err++; $display("FAIL reset_middeb act=%h exp=%h", {act_a, act_b}, {exp_vec(0), exp_vec(1)});
      end
      crit_raw = 4'b0000;
      for (int i = 0; i < 6; i++) step();
      n_cmp++;
      if ({act_a, act_b} !== 20'd0) begin
         n_err++; $display("FAIL reset_settle act=%h exp=%h", {act_a, act_b}, 20'd0);
      end
   endtask

   task automatic test_debounce();
      warn_raw = 2'b01;
      step(); step();
      warn_raw = 2'b00;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (state_a !== 2'b00 || warn_act_a !== 2'b00 || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
            n_err++; $display("FAIL deb_glitch act=%h exp=%h", {act_a, act_b}, {exp_vec(0), exp_vec(1)});
         end
      end
      warn_raw = 2'b01;
      step(); step();
      n_cmp++;
      if (warn_act_a !== 2'b00) begin
         n_err++; $display("FAIL deb_edge2 warn_act=%b exp=%b", warn_act_a, 2'b00);
      end
      step();
      n_cmp++;
      if ({state_a, warn_act_a} !== {2'b00, 2'b01}) begin
         n_err++; $display("FAIL deb_edge3 got=%b exp=%b", {state_a, warn_act_a}, 4'b0001);
      end
      step();
      n_cmp++;
      if (state_a !== 2'b01 || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
         n_err++; $display("FAIL deb_edge4 state=%b exp=%b", state_a, 2'b01);
      end
   endtask

   task automatic test_escalate_ack();
      crit_raw = 4'b0100;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({state_a, alarm_a, crit_act_a, warn_act_a} !== 6'b10_1_1_00) begin
         n_err++; $display("FAIL esc_crit got=%b exp=%b", {state_a, alarm_a, crit_act_a, warn_act_a}, 6'b101100);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_cmp++;
      if ({state_a, alarm_a, crit_act_a} !== 4'b11_0_1 || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
         n_err++; $display("FAIL esc_ack got=%b exp=%b", {state_a, alarm_a, crit_act_a}, 4'b1101);
      end
   endtask

   task automatic test_rearm();
      int  n;
      bit  b_ok, m_ok;
      n = 0; b_ok = 1'b1; m_ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (n == 0 && state_a == 2'b10) n = i;
         if (state_b !== 2'b11) b_ok = 1'b0;
         if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)}) m_ok = 1'b0;
      end
      n_cmp++;
      if (n != 16) begin
         n_err++; $display("FAIL rearm_16 cycles=%0d exp=%0d", n, 16);
      end
      n_cmp++;
      if (!b_ok) begin
         n_err++; $display("FAIL rearm_off state_b=%b exp=%b", state_b, 2'b11);
      end
      n_cmp++;
      if (!m_ok || alarm_a !== 1'b1) begin
         n_err++; $display("FAIL rearm_model act=%h exp=%h", {act_a, act_b}, {exp_vec(0), exp_vec(1)});
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_cmp++;
      if ({state_a, state_b} !== 4'b11_11) begin
         n_err++; $display("FAIL rearm_reack got=%b exp=%b", {state_a, state_b}, 4'b1111);
      end
   endtask

   task automatic test_clear_priority();
      warn_raw = 2'b10;
      crit_raw = 4'b0000;
      for (int i = 0; i < DEB; i++) step();
      n_cmp++;
      if ({state_a, warn_act_a, crit_act_a} !== {2'b11, 2'b10, 1'b0}) begin
         n_err++; $display("FAIL clr_filt got=%b exp=%b", {state_a, warn_act_a, crit_act_a}, 5'b11100);
      end
      step();
      n_cmp++;
      if ({state_a, state_b, warn_act_a} !== {2'b01, 2'b01, 2'b10} || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
         n_err++; $display("FAIL clr_exit got=%b exp=%b", {state_a, state_b, warn_act_a}, 6'b010110);
      end
      crit_raw = 4'b0001;
      for (int i = 0; i < DEB + 1; i++) step();
      crit_raw = 4'b0000;
      for (int i = 0; i < DEB; i++) step();
      ack = 1'b1;
      step();
      ack = 1'b0;
      n_cmp++;
      if ({state_a, state_b} !== 4'b01_01 || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
         n_err++; $display("FAIL clr_ack_same got=%b exp=%b", {state_a, state_b}, 4'b0101);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < NW; b++) if ($urandom_range(0, 5) == 0) warn_raw[b] = ~warn_raw[b];
         for (int b = 0; b < NC; b++) if ($urandom_range(0, 7) == 0) crit_raw[b] = ~crit_raw[b];
         ack       = ($urandom_range(0, 3) == 0);
         clr_cause = ($urandom_range(0, 9) == 0);
         step();
         n_cmp++;
         if ({act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
            n_err++;
            if (bad < 10) $display("FAIL random_%0d act=%h exp=%h", i, {act_a, act_b}, {exp_vec(0), exp_vec(1)});
            bad++;
         end
      end
      ack = 1'b0; clr_cause = 1'b0; warn_raw = '0; crit_raw = '0;
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_cause_log();
      clr_cause = 1'b1;
      step();
      clr_cause = 1'b0;
`ifdef MEDEVAC_CAUSE_LOG_EN
      n_cmp++;
      if (cause_a !== 4'b0000) begin
         n_err++; $display("FAIL cause_init got=%b exp=%b", cause_a, 4'b0000);
      end
      crit_raw = 4'b0010;
      for (int i = 0; i < 5; i++) step();
      crit_raw = 4'b0000;
      for (int i = 0; i < 5; i++) step();
      crit_raw = 4'b1000;
      for (int i = 0; i < 5; i++) step();
      crit_raw = 4'b0000;
      for (int i = 0; i < 6; i++) step();
      n_cmp++;
      if (cause_a !== 4'b1010 || cause_b !== 4'b1010) begin
         n_err++; $display("FAIL cause_sticky got=%b exp=%b", cause_a, 4'b1010);
      end
      clr_cause = 1'b1;
      step();
      clr_cause = 1'b0;
      n_cmp++;
      if (cause_a !== 4'b0000) begin
         n_err++; $display("FAIL cause_clear got=%b exp=%b", cause_a, 4'b0000);
      end
      crit_raw = 4'b0010;
      for (int i = 0; i < DEB + 1; i++) step();
      clr_cause = 1'b1;
      step();
      clr_cause = 1'b0;
      n_cmp++;
      if (cause_a !== 4'b0010 || {act_a, act_b} !== {exp_vec(0), exp_vec(1)}) begin
         n_err++; $display("FAIL cause_collide got=%b exp=%b", cause_a, 4'b0010);
      end
`else
      crit_raw = 4'b1010;
      for (int i = 0; i < 5; i++) step();
      clr_cause = 1'b1;
      step();
      clr_cause = 1'b0;
      n_cmp++;
      if ({cause_a, cause_b} !== 8'd0 || crit_act_a !== 1'b1) begin
         n_err++; $display("FAIL cause_off got=%b exp=%b", {cause_a, cause_b}, 8'd0);
      end
`endif
      crit_raw = 4'b0000;
      for (int i = 0; i < 6; i++) step();
   endtask

   initial begin
      step(); step();
      rst = 1'b0;
      test_reset();
      test_debounce();
      test_escalate_ack();
      test_rearm();
      test_clear_priority();
      test_random();
      test_cause_log();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
